// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the core command sequencer:
// FSM states and data-path condition codes.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_TRANS,
        ST_PROC,
        ST_FINISH
    } state_t;

    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_IN   = 3'b100;
    localparam logic [2:0] COND_MEM  = 3'b010;
    localparam logic [2:0] COND_REG  = 3'b001;

endpackage

// File: rtl/core_ctrl_timer.sv
// Watchdog for the sequencer: counts while enabled,
// flags expiry when the counter saturates at all-ones.
module core_ctrl_timer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic ctrl_clk,
    input  logic ctrl_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == '1);

endmodule

// File: rtl/core_sequencer.sv
// Command sequencer: store to memory, then chunked
// mem->reg transfers each followed by a processing pass.
module core_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int INST_W    = 3,
    parameter int LEN_W     = 6,
    parameter int CHUNK     = 8,
    parameter int TIMEOUT_W = 8
) (
    input  logic              ctrl_clk,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_valid_inst,
    input  logic              ctrl_valid_data,
    input  logic [INST_W-1:0] ctrl_instruction,
    input  logic [LEN_W-1:0]  ctrl_data_in_size,
    output logic              ctrl_ready,
    output logic [2:0]        ctrl_data_condition,
    output logic [LEN_W-1:0]  mc_data_length,
    input  logic              mc_done,
    output logic [INST_W-1:0] procc_instruction,
    output logic              procc_start,
    input  logic              procc_done,
    output logic [LEN_W-1:0]  ctrl_remaining,
    output logic              ctrl_busy,
    output logic              ctrl_done,
    output logic              ctrl_error
);

    state_t            state;
    logic [INST_W-1:0] opcode;
    logic [LEN_W-1:0]  next_len;
    logic              accept;
    logic              advance;
    logic              wd_en;
    logic              wd_clear;
    logic              wd_expired;

    assign accept = ctrl_ready & ctrl_valid_inst & ctrl_valid_data;
    assign next_len = (ctrl_remaining > LEN_W'(CHUNK))
                    ? LEN_W'(CHUNK) : ctrl_remaining;
    assign ctrl_busy = ~ctrl_ready;

    always_comb begin
        advance = 1'b0;
        wd_en   = 1'b0;
        unique case (state)
            ST_STORE, ST_TRANS: begin
                advance = mc_done;
                wd_en   = 1'b1;
            end
            ST_PROC: begin
                advance = procc_done;
                wd_en   = 1'b1;
            end
            default: begin
                advance = 1'b0;
                wd_en   = 1'b0;
            end
        endcase
    end

    // Any state change restarts the watchdog window.
    assign wd_clear = ~wd_en | advance;

    core_ctrl_timer #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_timer (
        .ctrl_clk    (ctrl_clk),
        .ctrl_reset_n(ctrl_reset_n),
        .clear       (wd_clear),
        .enable      (wd_en),
        .expired     (wd_expired)
    );

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state               <= ST_IDLE;
            opcode              <= '0;
            ctrl_ready          <= 1'b1;
            ctrl_data_condition <= COND_NONE;
            mc_data_length      <= '0;
            procc_instruction   <= '0;
            procc_start         <= 1'b0;
            ctrl_remaining      <= '0;
            ctrl_done           <= 1'b0;
            ctrl_error          <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            if (wd_en && !advance && wd_expired) begin
                ctrl_error          <= 1'b1;
                ctrl_data_condition <= COND_NONE;
                procc_start         <= 1'b0;
                mc_data_length      <= '0;
                ctrl_remaining      <= '0;
                ctrl_ready          <= 1'b1;
                state               <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            opcode         <= ctrl_instruction;
                            ctrl_remaining <= ctrl_data_in_size;
                            ctrl_error     <= 1'b0;
                            ctrl_ready     <= 1'b0;
                            if (ctrl_data_in_size == '0) begin
                                ctrl_done <= 1'b1;
                                state     <= ST_FINISH;
                            end else begin
                                ctrl_data_condition <= COND_IN;
                                mc_data_length      <= ctrl_data_in_size;
                                state               <= ST_STORE;
                            end
                        end
                    end
                    ST_STORE: begin
                        if (mc_done) begin
                            ctrl_data_condition <= COND_MEM;
                            mc_data_length      <= next_len;
                            state               <= ST_TRANS;
                        end
                    end
                    ST_TRANS: begin
                        if (mc_done) begin
                            ctrl_remaining      <= ctrl_remaining - mc_data_length;
                            ctrl_data_condition <= COND_REG;
                            procc_start         <= 1'b1;
                            procc_instruction   <= opcode;
                            state               <= ST_PROC;
                        end
                    end
                    ST_PROC: begin
                        if (procc_done) begin
                            procc_start <= 1'b0;
                            if (ctrl_remaining != '0) begin
                                ctrl_data_condition <= COND_MEM;
                                mc_data_length      <= next_len;
                                state               <= ST_TRANS;
                            end else begin
                                ctrl_data_condition <= COND_NONE;
                                mc_data_length      <= '0;
                                ctrl_done           <= 1'b1;
                                state               <= ST_FINISH;
                            end
                        end
                    end
                    ST_FINISH: begin
                        ctrl_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    default: begin
                        ctrl_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
